// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing outputs of vga_sync_gen; pattern ports exist only with VGA_SYNC_PATTERN_EN.
interface vga_sync_gen_if;
  logic       o_HSync;
  logic       o_VSync;
  logic       o_HSync_Dly;
  logic       o_VSync_Dly;
  logic       o_Active;
  logic [9:0] o_Col;
  logic [9:0] o_Row;
  logic       o_Line_Start;
  logic       o_Frame_Start;
  logic [7:0] o_Frame_Count;
`ifdef VGA_SYNC_PATTERN_EN
  logic [2:0] o_Pat_Red;
  logic [2:0] o_Pat_Grn;
  logic [2:0] o_Pat_Blu;
  modport master(output o_HSync, o_VSync, o_HSync_Dly, o_VSync_Dly, o_Active, o_Col, o_Row,
                 o_Line_Start, o_Frame_Start, o_Frame_Count, o_Pat_Red, o_Pat_Grn, o_Pat_Blu);
  modport slave(input o_HSync, o_VSync, o_HSync_Dly, o_VSync_Dly, o_Active, o_Col, o_Row,
                o_Line_Start, o_Frame_Start, o_Frame_Count, o_Pat_Red, o_Pat_Grn, o_Pat_Blu);
`else
  modport master(output o_HSync, o_VSync, o_HSync_Dly, o_VSync_Dly, o_Active, o_Col, o_Row,
                 o_Line_Start, o_Frame_Start, o_Frame_Count);
  modport slave(input o_HSync, o_VSync, o_HSync_Dly, o_VSync_Dly, o_Active, o_Col, o_Row,
                o_Line_Start, o_Frame_Start, o_Frame_Count);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator with delayed sync copies.
// Optional colour-bar pattern outputs when VGA_SYNC_PATTERN_EN is defined.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  vga_sync_gen_if.master bus
);
  localparam logic [9:0] HT_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VT_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA    = 10'(H_ACTIVE);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  localparam logic [9:0] HS0   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1   = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic       r_run;
  logic [9:0] r_col, r_row;
  logic       r_hs, r_vs, r_act, r_ls, r_fs;
  logic [7:0] r_cnt;
  logic       w_eol, w_act;
  logic [9:0] w_col, w_row;
  // r_run is low for the reset state so the first free edge loads (0,0) rather than advancing
  always_comb begin
    w_eol = r_col == HT_M1;
    w_col = (!r_run || w_eol) ? '0 : r_col + 10'd1;
    w_row = !r_run ? '0 : !w_eol ? r_row : (r_row == VT_M1) ? '0 : r_row + 10'd1;
    w_act = (w_col < HA) && (w_row < VA);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_run <= 1'b0;
      r_col <= '0;
      r_row <= '0;
      r_act <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      r_col <= w_col;
      r_row <= w_row;
      r_act <= w_act;
      r_hs  <= !((w_col >= HS0) && (w_col < HS1));
      r_vs  <= !((w_row >= VS0) && (w_row < VS1));
      r_ls  <= w_col == '0;
      r_fs  <= (w_col == '0) && (w_row == '0);
      r_cnt <= r_cnt + 8'(r_run && (w_col == '0) && (w_row == '0));
    end
  end
  assign bus.o_Col         = r_col;
  assign bus.o_Row         = r_row;
  assign bus.o_Active      = r_act;
  assign bus.o_HSync       = r_hs;
  assign bus.o_VSync       = r_vs;
  assign bus.o_Line_Start  = r_ls;
  assign bus.o_Frame_Start = r_fs;
  assign bus.o_Frame_Count = r_cnt;
  if (SYNC_DELAY == 0) begin : g_nodly
    assign bus.o_HSync_Dly = r_hs;
    assign bus.o_VSync_Dly = r_vs;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] r_hd, r_vd;
    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        r_hd <= '1;
        r_vd <= '1;
      end else begin
        r_hd <= SYNC_DELAY'({r_hd, r_hs});
        r_vd <= SYNC_DELAY'({r_vd, r_vs});
      end
    end
    assign bus.o_HSync_Dly = r_hd[SYNC_DELAY-1];
    assign bus.o_VSync_Dly = r_vd[SYNC_DELAY-1];
  end
`ifdef VGA_SYNC_PATTERN_EN
  logic [2:0] r_red, r_grn, r_blu;
  logic [2:0] w_idx;
  assign w_idx = 3'(w_col / 10'(H_ACTIVE / 8));
  always_ff @(posedge i_Clk) begin
    if (i_Reset || !w_act) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
    end else begin
      r_red <= {3{w_idx[2]}};
      r_grn <= {3{w_idx[1]}};
      r_blu <= {3{w_idx[0]}};
    end
  end
  assign bus.o_Pat_Red = r_red;
  assign bus.o_Pat_Grn = r_grn;
  assign bus.o_Pat_Blu = r_blu;
`endif
endmodule
